pbit_sweep_scheduler: RTL

Sequencer for a p-bit network built from AND/HA/FA gate systems. It issues one-cycle update strobes to each p-bit in fixed index order, so sampling is sequential (Gibbs-style). Each strobe is followed by a settle window that lets the combinational gate/fusion network propagate before the next update. It counts sweeps, steps the shared 2-bit `bit_shift` annealing control, and reports completion through a start/busy/done handshake.

---
 rtl/pbit_sched_pkg.sv | 19 +
 rtl/pbit_anneal_step.sv | 44 ++++
 rtl/pbit_sweep_scheduler.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pbit_sched_pkg.sv
// Shared types and helpers for the p-bit sweep scheduler.
// Optional sampling port set is enabled with PBIT_SCHED_SAMPLE_EN.
package pbit_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } sched_state_t;

  localparam logic [1:0] BIT_SHIFT_MAX = 2'd3;

  // Index width for a counter over 0..n-1, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pbit_anneal_step.sv
// Anneal counter plus saturating bit_shift register; steps once per
// ANNEAL_SWEEPS completed sweeps (ANNEAL_SWEEPS=0 keeps bit_shift at 0).
module pbit_anneal_step
  import pbit_sched_pkg::*;
#(
  parameter int ANNEAL_SWEEPS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       sweep_tick,
  output logic [1:0] bit_shift
);

  localparam int CNT_W = idx_w(ANNEAL_SWEEPS);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((ANNEAL_SWEEPS > 0) ? ANNEAL_SWEEPS - 1 : 0);
  localparam logic ANNEAL_ON = (ANNEAL_SWEEPS > 0);

  logic [CNT_W-1:0] anneal_cnt_reg;
  logic [1:0]       bit_shift_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anneal_cnt_reg <= '0;
      bit_shift_reg  <= '0;
    end else if (clear) begin
      anneal_cnt_reg <= '0;
      bit_shift_reg  <= '0;
    end else if (sweep_tick && ANNEAL_ON) begin
      if (anneal_cnt_reg == CNT_LAST) begin
        anneal_cnt_reg <= '0;
        if (bit_shift_reg != BIT_SHIFT_MAX) begin
          bit_shift_reg <= bit_shift_reg + 2'd1;
        end
      end else begin
        anneal_cnt_reg <= anneal_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign bit_shift = bit_shift_reg;

endmodule

// File: rtl/pbit_sweep_scheduler.sv
// Sequential (Gibbs-style) update strobe scheduler for a p-bit network with
// settle windows, sweep counting and annealing. Optional: PBIT_SCHED_SAMPLE_EN.
module pbit_sweep_scheduler
  import pbit_sched_pkg::*;
#(
  parameter int N_PBITS       = 5,
  parameter int SETTLE_CYCLES = 2,
  parameter int ANNEAL_SWEEPS = 4,
  parameter int SWEEP_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [SWEEP_W-1:0] n_sweeps,
  output logic [N_PBITS-1:0] upd_en,
  output logic [1:0]         bit_shift,
  output logic               busy,
  output logic               done,
  output logic [SWEEP_W-1:0] sweep_cnt
`ifdef PBIT_SCHED_SAMPLE_EN
  ,
  input  logic [N_PBITS-1:0] pbit_state,
  output logic [N_PBITS-1:0] sample,
  output logic               sample_valid
`endif
);

  localparam int IDX_W = idx_w(N_PBITS);
  localparam int SET_W = idx_w(SETTLE_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PBITS - 1);
  localparam logic [SET_W-1:0] SET_LAST =
    SET_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  sched_state_t       state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg;
  logic [SET_W-1:0]   settle_cnt_reg;
  logic [SWEEP_W-1:0] target_reg;
  logic [SWEEP_W-1:0] sweep_cnt_reg;
  logic [SWEEP_W-1:0] sweep_cnt_inc;

  logic accept;
  logic slot_end;
  logic sweep_tick;
  logic run_done;

  assign accept        = (state_reg == IDLE) && start && !abort;
  assign sweep_cnt_inc = sweep_cnt_reg + SWEEP_W'(1);
  assign sweep_tick    = slot_end && (idx_reg == IDX_LAST);
  assign run_done      = sweep_tick && (sweep_cnt_inc == target_reg);

  // A slot ends on the strobe itself when there is no settle window.
  always_comb begin
    slot_end = 1'b0;
    if (!abort) begin
      if ((state_reg == UPDATE) && (SETTLE_CYCLES == 0)) slot_end = 1'b1;
      if ((state_reg == SETTLE) && (settle_cnt_reg == SET_LAST)) slot_end = 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = (n_sweeps == '0) ? DONE : UPDATE;
      end
      UPDATE, SETTLE: begin
        if (abort)         state_next = IDLE;
        else if (slot_end) state_next = run_done ? DONE : UPDATE;
        else               state_next = SETTLE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      settle_cnt_reg <= '0;
      target_reg     <= '0;
      sweep_cnt_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      settle_cnt_reg <= ((state_reg == SETTLE) && !slot_end) ?
                        settle_cnt_reg + SET_W'(1) : '0;
      if (accept) begin
        target_reg    <= n_sweeps;
        sweep_cnt_reg <= '0;
        idx_reg       <= '0;
      end else if (slot_end) begin
        if (idx_reg == IDX_LAST) begin
          idx_reg       <= '0;
          sweep_cnt_reg <= sweep_cnt_inc;
        end else begin
          idx_reg <= idx_reg + IDX_W'(1);
        end
      end
    end
  end

  pbit_anneal_step #(
    .ANNEAL_SWEEPS(ANNEAL_SWEEPS)
  ) u_anneal (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept),
    .sweep_tick(sweep_tick),
    .bit_shift (bit_shift)
  );

  // Strobe is suppressed in the cycle abort is seen.
  generate
    for (genvar gi = 0; gi < N_PBITS; gi++) begin : g_strobe
      assign upd_en[gi] = (state_reg == UPDATE) && !abort &&
                          (idx_reg == IDX_W'(gi));
    end
  endgenerate

  assign busy      = (state_reg == UPDATE) || (state_reg == SETTLE);
  assign done      = (state_reg == DONE) && !abort;
  assign sweep_cnt = sweep_cnt_reg;

`ifdef PBIT_SCHED_SAMPLE_EN
  logic [N_PBITS-1:0] sample_reg;
  logic               sample_valid_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_reg       <= '0;
      sample_valid_reg <= 1'b0;
    end else begin
      sample_valid_reg <= sweep_tick;
      if (sweep_tick) sample_reg <= pbit_state;
    end
  end

  assign sample       = sample_reg;
  assign sample_valid = sample_valid_reg;
`endif

endmodule
